// File: rtl/mux_pkg.sv
// Shared definitions for the mux datapath: symbol width/type and the packer's default sizes.
package mux_pkg;
  localparam int SYM_W      = 2;
  localparam int WORD_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

  typedef logic [SYM_W-1:0] sym_t;
endpackage

// File: rtl/sym_accumulator.sv
// Collects symbols into slots of a word-wide accumulator and flags when a word is complete,
// either because the last slot was filled or because a flush closed a partial word.
module sym_accumulator
  import mux_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              reset_L,
  input  sym_t              data_in,
  input  logic              accept,
  input  logic              flush,
  input  logic              handoff,
  output logic [WORD_W-1:0] acc,
  output logic              handoff_req
);
  localparam int SYMS = WORD_W / SYM_W;
  localparam int CW   = $clog2(SYMS);

  logic [SYMS-1:0][SYM_W-1:0] acc_reg, acc_next;
  logic [CW-1:0] sym_cnt_reg, sym_cnt_next, base_cnt;
  logic acc_full_reg, acc_full_next;
  logic flush_pending_reg, flush_pending_next;
  logic stalled, complete_full, complete_flush;

  assign handoff_req = acc_full_reg | flush_pending_reg;
  assign stalled     = handoff_req & ~handoff;

  // A hand-off this cycle empties the accumulator, so a same-cycle symbol starts at slot 0.
  assign base_cnt       = handoff ? '0 : sym_cnt_reg;
  assign complete_full  = accept & (base_cnt == CW'(SYMS - 1));
  assign complete_flush = flush & ~stalled & ~complete_full & (accept | (base_cnt != '0));

  for (genvar gi = 0; gi < SYMS; gi++) begin : g_slot
    assign acc_next[gi] = (accept && (base_cnt == CW'(gi))) ? data_in
                        : (handoff ? '0 : acc_reg[gi]);
  end

  always_comb begin
    sym_cnt_next       = complete_full ? '0 : base_cnt + CW'(accept);
    acc_full_next      = stalled ? acc_full_reg : complete_full;
    flush_pending_next = stalled ? flush_pending_reg : complete_flush;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      acc_reg           <= '0;
      sym_cnt_reg       <= '0;
      acc_full_reg      <= 1'b0;
      flush_pending_reg <= 1'b0;
    end else begin
      acc_reg           <= acc_next;
      sym_cnt_reg       <= sym_cnt_next;
      acc_full_reg      <= acc_full_next;
      flush_pending_reg <= flush_pending_next;
    end
  end

  assign acc = acc_reg;
endmodule

// File: rtl/mux_word_packer.sv
// Packs the 2-bit symbol stream into WORD_W-bit words (LSB first) behind a double-buffered
// valid/ready output stage, counting every word handed to the consumer.
module mux_word_packer
  import mux_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_L,
  input  sym_t              data_in,
  input  logic              valid_in,
  output logic              in_ready,
  input  logic              flush,
  output logic [WORD_W-1:0] data_out,
  output logic              valid_out,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  word_cnt
);
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] data_out_reg;
  logic              valid_out_reg;
  logic [CNT_W-1:0]  word_cnt_reg;
  logic handoff_req, out_free, handoff, accept;

  // The output register is free when empty or being drained this very cycle.
  assign out_free = ~valid_out_reg | out_ready;
  assign handoff  = handoff_req & out_free;
  assign in_ready = reset_L & (~handoff_req | out_free);
  assign accept   = valid_in & in_ready;

  sym_accumulator #(
    .WORD_W (WORD_W)
  ) u_acc (
    .clk         (clk),
    .reset_L     (reset_L),
    .data_in     (data_in),
    .accept      (accept),
    .flush       (flush),
    .handoff     (handoff),
    .acc         (acc),
    .handoff_req (handoff_req)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out_reg  <= '0;
      valid_out_reg <= 1'b0;
      word_cnt_reg  <= '0;
    end else begin
      if (handoff) begin
        data_out_reg  <= acc;
        valid_out_reg <= 1'b1;
      end else if (out_ready) begin
        valid_out_reg <= 1'b0;
      end
      if (valid_out_reg && out_ready) begin
        word_cnt_reg <= word_cnt_reg + 1'b1;
      end
    end
  end

  assign data_out  = data_out_reg;
  assign valid_out = valid_out_reg;
  assign word_cnt  = word_cnt_reg;
endmodule
